// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: synchronizes the raw rx pin, samples each bit at mid-period and
// emits one-cycle valid / framing-error strobes alongside the recovered byte.
module uart_rx_frame #(
    parameter int unsigned CLOCKS_PER_BAUD = 868,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst_n_in,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       frame_err_out,
    output logic       busy_out
);

    localparam int unsigned CntW = $clog2(CLOCKS_PER_BAUD);
    localparam logic [CntW-1:0] CntLast = CntW'(CLOCKS_PER_BAUD - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLOCKS_PER_BAUD / 2 - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   rxs;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], rx};
    assign rxs    = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= StIdle;
            sync_q      <= '1;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rxs) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A start bit that is high again at mid-bit was only a glitch.
                    state_d = rxs ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                // Linger one cycle after a good stop bit so busy covers the valid pulse.
                if (valid_q) begin
                    state_d = StIdle;
                end else if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (rxs) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StWaitHigh;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitHigh: begin
                if (rxs) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        busy_out      = (state_q != StIdle);
        data_out      = data_q;
        valid_out     = valid_q;
        frame_err_out = frame_err_q;
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at 8 clocks per bit: clean frames, back-to-back frames,
// start glitch, framing error with break, mid-frame reset and +/-3% baud error.
module tb_uart_rx_frame;

    localparam int CPB    = 8;
    localparam int SYNC   = 2;
    localparam int PERIOD = 100;
    localparam int BIT    = CPB * PERIOD;
    localparam int LAT    = SYNC + 1 + CPB / 2 + 9 * CPB;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] data_out;
    logic       valid_out;
    logic       frame_err_out;
    logic       busy_out;

    uart_rx_frame #(
        .CLOCKS_PER_BAUD(CPB),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk          (clk),
        .rst_n_in     (rst_n),
        .rx           (rx),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .frame_err_out(frame_err_out),
        .busy_out     (busy_out)
    );

    always #(PERIOD / 2) clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge.
    int         valid_cnt = 0;
    int         ferr_cnt  = 0;
    int         both_cnt  = 0;
    int         busy_run  = 0;
    int         busy_max  = 0;
    logic       busy_clr  = 1'b0;
    logic [7:0] vdata [8];
    int         vtime [8];

    always @(negedge clk) begin
        if (valid_out) begin
            vdata[valid_cnt % 8] <= data_out;
            vtime[valid_cnt % 8] <= cyc;
            valid_cnt            <= valid_cnt + 1;
        end
        if (frame_err_out) ferr_cnt <= ferr_cnt + 1;
        if (valid_out && frame_err_out) both_cnt <= both_cnt + 1;
        busy_run <= busy_out ? busy_run + 1 : 0;
        if (busy_clr) busy_max <= 0;
        else if (busy_out && (busy_run + 1 > busy_max)) busy_max <= busy_run + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int bit_t, input logic stop);
        rx = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_t);
        end
        rx = stop;
        #(bit_t);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int         vb;
    int         fb;
    int         t0;
    int         d;
    logic [7:0] pat;

    initial begin
        // Reset values
        wait_cyc(3);
        chk("rst_data", int'(data_out), 0);
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_ferr", int'(frame_err_out), 0);
        chk("rst_busy", int'(busy_out), 0);
        rst_n = 1'b1;
        wait_cyc(5);
        chk("idle_busy", int'(busy_out), 0);

        // Single 0x55 at exact baud, with latency check
        vb = valid_cnt; fb = ferr_cnt;
        @(posedge clk); #1;
        t0 = cyc;
        send(8'h55, BIT, 1'b1);
        wait_cyc(10);
        chk("b55_count", valid_cnt - vb, 1);
        chk("b55_data", int'(vdata[vb % 8]), 'h55);
        chk("b55_hold", int'(data_out), 'h55);
        chk("b55_ferr", ferr_cnt - fb, 0);
        chk("b55_busy", int'(busy_out), 0);
        d = vtime[vb % 8] - t0;
        chk("b55_latency", int'(d >= LAT - 1 && d <= LAT + 1), 1);

        // Back-to-back 0xA5, 0x3C
        vb = valid_cnt; fb = ferr_cnt;
        @(posedge clk); #1;
        send(8'hA5, BIT, 1'b1);
        send(8'h3C, BIT, 1'b1);
        wait_cyc(10);
        chk("b2b_count", valid_cnt - vb, 2);
        chk("b2b_data0", int'(vdata[vb % 8]), 'hA5);
        chk("b2b_data1", int'(vdata[(vb + 1) % 8]), 'h3C);
        d = vtime[(vb + 1) % 8] - vtime[vb % 8];
        chk("b2b_gap", int'(d >= 10 * CPB - 2 && d <= 10 * CPB + 2), 1);
        chk("b2b_ferr", ferr_cnt - fb, 0);

        // Three-cycle start glitch
        busy_clr = 1'b1;
        wait_cyc(1);
        busy_clr = 1'b0;
        vb = valid_cnt; fb = ferr_cnt;
        rx = 1'b0;
        wait_cyc(3);
        rx = 1'b1;
        wait_cyc(20);
        chk("glitch_valid", valid_cnt - vb, 0);
        chk("glitch_ferr", ferr_cnt - fb, 0);
        chk("glitch_busy_seen", int'(busy_max >= 1), 1);
        chk("glitch_busy_max", int'(busy_max <= 4 + SYNC), 1);
        chk("glitch_busy_end", int'(busy_out), 0);

        // 0x81 with low stop bit, then break held for 40 cycles
        vb = valid_cnt; fb = ferr_cnt;
        @(posedge clk); #1;
        send(8'h81, BIT, 1'b0);
        wait_cyc(40);
        chk("ferr_count", ferr_cnt - fb, 1);
        chk("ferr_valid", valid_cnt - vb, 0);
        chk("ferr_data_hold", int'(data_out), 'h3C);
        chk("ferr_busy_low", int'(busy_out), 1);
        rx = 1'b1;
        wait_cyc(10);
        chk("ferr_busy_end", int'(busy_out), 0);
        chk("ferr_single", ferr_cnt - fb, 1);

        // Reset during bit 4 of 0xF0
        pat = 8'hF0;
        @(posedge clk); #1;
        rx = 1'b0;
        #(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = pat[i];
            #(BIT);
        end
        rx = pat[4];
        #(BIT / 2);
        chk("mid_busy", int'(busy_out), 1);
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        chk("mrst_data", int'(data_out), 0);
        chk("mrst_valid", int'(valid_out), 0);
        chk("mrst_ferr", int'(frame_err_out), 0);
        chk("mrst_busy", int'(busy_out), 0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(5);
        vb = valid_cnt; fb = ferr_cnt;
        send(8'h0F, BIT, 1'b1);
        wait_cyc(10);
        chk("post_rst_count", valid_cnt - vb, 1);
        chk("post_rst_data", int'(data_out), 'h0F);
        chk("post_rst_ferr", ferr_cnt - fb, 0);

        // +3% slow 0x00, -3% fast 0xFF
        vb = valid_cnt; fb = ferr_cnt;
        @(posedge clk); #1;
        send(8'h00, BIT * 103 / 100, 1'b1);
        wait_cyc(5);
        send(8'hFF, BIT * 97 / 100, 1'b1);
        wait_cyc(10);
        chk("baud_count", valid_cnt - vb, 2);
        chk("baud_data0", int'(vdata[vb % 8]), 'h00);
        chk("baud_data1", int'(vdata[(vb + 1) % 8]), 'hFF);
        chk("baud_ferr", ferr_cnt - fb, 0);

        chk("never_both", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
